// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: state encoding,
// reset PC, timeout limit and an alignment helper.
package ifu_fetch_pkg;

    localparam int              IFU_ISA_WIDTH = 32;
    localparam logic [31:0]     IFU_RESET_PC  = 32'h8000_0000;
    localparam int              IFU_TO_WIDTH  = 8;
    localparam logic [7:0]      IFU_TIMEOUT   = 8'd255;

    typedef enum logic [2:0] {
        IFU_REQ   = 3'd0,
        IFU_WAIT  = 3'd1,
        IFU_VALID = 3'd2,
        IFU_EXEC  = 3'd3,
        IFU_ERR   = 3'd4
    } ifu_state_e;

    // Instructions are word aligned; any set low bit in a PC is a fault.
    function automatic logic misaligned(input logic [1:0] pc_lsbs);
        return pc_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-side buses: instruction-memory request/response and the decoder handoff.
// master = fetch stage, slave = memory + decoder side.
interface ifu_fetch_if
    import ifu_fetch_pkg::*;
#(
    parameter int ISA_WIDTH = IFU_ISA_WIDTH
) ();
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [ISA_WIDTH-1:0] imem_req_addr;
    logic                 imem_resp_valid;
    logic [31:0]          imem_resp_data;
    logic                 imem_resp_err;
    logic [31:0]          inst;
    logic                 inst_valid;
    logic                 inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst, inst_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst, inst_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
    );
endinterface

// File: rtl/ifu_fetch_reg.sv
// Parameterised register with asynchronous active-low reset value and write enable.
module ifu_fetch_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (wen) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction per PC and
// hands it to the decoder; halts in ERR on a bus fault, timeout or bad PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                    ISA_WIDTH = IFU_ISA_WIDTH,
    parameter logic [ISA_WIDTH-1:0]  RESET_PC  = IFU_RESET_PC,
    parameter int                    TO_WIDTH  = IFU_TO_WIDTH,
    parameter logic [TO_WIDTH-1:0]   TIMEOUT   = IFU_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] pc_in,
    input  logic                 pc_w_en,
    output logic [ISA_WIDTH-1:0] pc_out,
    ifu_fetch_if.master          bus,
    output logic                 fetch_err,
    output logic [31:0]          fetch_cnt
);
    ifu_state_e          state_d, state_q;
    logic [TO_WIDTH-1:0] to_cnt_d, to_cnt_q;
    logic [31:0]         fetch_cnt_d, fetch_cnt_q;
    logic                req_valid_d, req_valid_q;
    logic                inst_valid_d, inst_valid_q;
    logic                fetch_err_d, fetch_err_q;
    logic                pc_load;
    logic                inst_load;
    logic [ISA_WIDTH-1:0] pc_q;
    logic [31:0]         inst_q;

    ifu_fetch_reg #(.WIDTH(ISA_WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk(clk), .rst(rst), .wen(pc_load), .d(pc_in), .q(pc_q)
    );

    ifu_fetch_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_inst_reg (
        .clk(clk), .rst(rst), .wen(inst_load), .d(bus.imem_resp_data), .q(inst_q)
    );

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        pc_load     = 1'b0;
        inst_load   = 1'b0;
        case (state_q)
            IFU_REQ: begin
                // Acceptance only counts once the request is actually visible.
                if (req_valid_q && bus.imem_req_ready) begin
                    state_d  = IFU_WAIT;
                    to_cnt_d = '0;
                end
            end
            IFU_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (bus.imem_resp_err) begin
                        state_d = IFU_ERR;
                    end else begin
                        inst_load   = 1'b1;
                        fetch_cnt_d = fetch_cnt_q + 32'd1;
                        state_d     = IFU_VALID;
                    end
                end else begin
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                    if (to_cnt_d == TIMEOUT) begin
                        state_d = IFU_ERR;
                    end
                end
            end
            IFU_VALID: begin
                if (bus.inst_ready) begin
                    if (pc_w_en) begin
                        pc_load = 1'b1;
                        state_d = misaligned(pc_in[1:0]) ? IFU_ERR : IFU_REQ;
                    end else begin
                        state_d = IFU_EXEC;
                    end
                end
            end
            IFU_EXEC: begin
                if (pc_w_en) begin
                    pc_load = 1'b1;
                    state_d = misaligned(pc_in[1:0]) ? IFU_ERR : IFU_REQ;
                end
            end
            IFU_ERR: begin
                state_d = IFU_ERR;
            end
            default: begin
                state_d = IFU_ERR;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        req_valid_d  = (state_d == IFU_REQ);
        inst_valid_d = (state_d == IFU_VALID);
        fetch_err_d  = (state_d == IFU_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IFU_REQ;
            to_cnt_q     <= '0;
            fetch_cnt_q  <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign pc_out             = pc_q;
    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst           = inst_q;
    assign bus.inst_valid     = inst_valid_q;
    assign fetch_err          = fetch_err_q;
    assign fetch_cnt          = fetch_cnt_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed corner cases plus randomized fetch/commit
// traffic, checked by scoreboards fed from a transaction-level PC/count model.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in;
    logic        pc_w_en;
    wire  [31:0] pc_out;
    wire         fetch_err;
    wire  [31:0] fetch_cnt;

    ifu_fetch_if #(.ISA_WIDTH(32)) bus_if ();

    ifu_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .pc_w_en   (pc_w_en),
        .pc_out    (pc_out),
        .bus       (bus_if.master),
        .fetch_err (fetch_err),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr_q[$];
    exp_t        exp_inst_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: compares every request and decoder handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: addr %h, expected no request", bus_if.imem_req_addr);
                end else begin
                    check("req_addr", bus_if.imem_req_addr, exp_addr_q.pop_front());
                end
            end
            if (bus_if.inst_valid && bus_if.inst_ready) begin
                if (exp_inst_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL inst_unexpected: inst %h, expected no handoff", bus_if.inst);
                end else begin
                    exp_t e;
                    e = exp_inst_q.pop_front();
                    check("hs_inst", bus_if.inst, e.inst);
                    check("hs_pc", pc_out, e.pc);
                    check("hs_cnt", fetch_cnt, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_in                  = '0;
        pc_w_en                = 1'b0;
        bus_if.imem_req_ready  = 1'b0;
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
        bus_if.imem_resp_err   = 1'b0;
        bus_if.inst_ready      = 1'b0;
    endtask

    // sel 0: wait for req_valid, sel 1: wait for inst_valid (bounded).
    task automatic wait_on(input int sel);
        int n = 0;
        while (((sel == 0) ? bus_if.imem_req_valid : bus_if.inst_valid) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check((sel == 0) ? "wait_req_valid" : "wait_inst_valid",
              {31'b0, (sel == 0) ? bus_if.imem_req_valid : bus_if.inst_valid}, 32'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        clear_inputs();
        exp_addr_q.delete();
        exp_inst_q.delete();
        tick();
        check("reset_pc", pc_out, RST_PC);
        rst       = 1'b1;
        model_pc  = RST_PC;
        model_cnt = 0;
    endtask

    task automatic fetch_to_valid(input logic [31:0] data);
        wait_on(0);
        exp_addr_q.push_back(model_pc);
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = data;
        model_cnt++;
        exp_inst_q.push_back('{data, model_pc, model_cnt});
        tick();
        bus_if.imem_resp_valid = 1'b0;
    endtask

    task automatic random_txn();
        logic [31:0] next_pc;
        logic [31:0] data;
        int          hold;
        wait_on(0);
        exp_addr_q.push_back(model_pc);
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            pc_w_en = 1'($urandom_range(0, 1));
            pc_in   = $urandom;
            bus_if.imem_resp_valid = 1'($urandom_range(0, 1));
            tick();
        end
        pc_w_en = 1'b0;
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_req_ready  = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        repeat ($urandom_range(1, 3) - 1) begin
            pc_w_en = 1'($urandom_range(0, 1));
            pc_in   = $urandom;
            tick();
        end
        pc_w_en = 1'b0;
        data = $urandom;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = data;
        model_cnt++;
        exp_inst_q.push_back('{data, model_pc, model_cnt});
        tick();
        bus_if.imem_resp_valid = 1'b0;
        wait_on(1);
        repeat ($urandom_range(0, 2)) begin
            pc_w_en = 1'($urandom_range(0, 1));
            pc_in   = $urandom;
            bus_if.imem_resp_valid = 1'($urandom_range(0, 1));
            tick();
        end
        pc_w_en = 1'b0;
        bus_if.imem_resp_valid = 1'b0;
        next_pc = RST_PC + ($urandom_range(0, 1023) << 2);
        bus_if.inst_ready = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            pc_w_en = 1'b1;
            pc_in   = next_pc;
            tick();
            bus_if.inst_ready = 1'b0;
            pc_w_en = 1'b0;
        end else begin
            tick();
            bus_if.inst_ready = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                bus_if.imem_resp_valid = 1'($urandom_range(0, 1));
                tick();
            end
            bus_if.imem_resp_valid = 1'b0;
            pc_w_en = 1'b1;
            pc_in   = next_pc;
            tick();
            pc_w_en = 1'b0;
        end
        model_pc = next_pc;
        check("txn_pc_after_commit", pc_out, model_pc);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        check("rst_pc_out", pc_out, RST_PC);
        check("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
        check("rst_inst", bus_if.inst, 32'd0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        check("rst_fetch_cnt", fetch_cnt, 32'd0);

        // First fetch straight out of reset, ready held high.
        bus_if.imem_req_ready = 1'b1;
        exp_addr_q.push_back(RST_PC);
        rst = 1'b1;
        tick();
        check("c1_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
        check("c1_addr", bus_if.imem_req_addr, RST_PC);
        tick();
        bus_if.imem_req_ready  = 1'b0;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = 32'h0000_0013;
        tick();
        bus_if.imem_resp_valid = 1'b0;
        check("c3_inst_valid", {31'b0, bus_if.inst_valid}, 32'd1);
        check("c3_inst", bus_if.inst, 32'h0000_0013);
        check("c3_fetch_cnt", fetch_cnt, 32'd1);

        // Decoder accept and commit in the same cycle.
        exp_inst_q.push_back('{32'h0000_0013, RST_PC, 32'd1});
        bus_if.inst_ready = 1'b1;
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0010;
        tick();
        bus_if.inst_ready = 1'b0;
        pc_w_en = 1'b0;
        check("same_cycle_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
        check("same_cycle_addr", bus_if.imem_req_addr, 32'h8000_0010);

        // Memory stalls for five cycles; commits in REQ are ignored.
        exp_addr_q.push_back(32'h8000_0010);
        for (int i = 0; i < 5; i++) begin
            pc_w_en = 1'b1;
            pc_in   = 32'h8000_0abc;
            tick();
            check("stall_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
            check("stall_addr", bus_if.imem_req_addr, 32'h8000_0010);
        end
        pc_w_en = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        check("accept_req_dropped", {31'b0, bus_if.imem_req_valid}, 32'd0);

        // Commit during WAIT leaves the PC alone.
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0044;
        tick();
        pc_w_en = 1'b0;
        check("wait_commit_pc", pc_out, 32'h8000_0010);
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = 32'h0010_0093;
        exp_inst_q.push_back('{32'h0010_0093, 32'h8000_0010, 32'd2});
        tick();
        bus_if.imem_resp_valid = 1'b0;
        check("second_inst_valid", {31'b0, bus_if.inst_valid}, 32'd1);
        check("second_fetch_cnt", fetch_cnt, 32'd2);

        // Commit in VALID without inst_ready is ignored.
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0099;
        tick();
        pc_w_en = 1'b0;
        check("valid_commit_pc", pc_out, 32'h8000_0010);
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        check("exec_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
        check("exec_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0020;
        tick();
        pc_w_en = 1'b0;
        check("exec_commit_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
        check("exec_commit_addr", bus_if.imem_req_addr, 32'h8000_0020);

        model_pc  = 32'h8000_0020;
        model_cnt = 32'd2;
        for (int t = 0; t < 40; t++) begin
            random_txn();
        end
        check("rand_addr_q_empty", exp_addr_q.size(), 32'd0);
        check("rand_inst_q_empty", exp_inst_q.size(), 32'd0);

        // Bus fault, then ERR ignores everything.
        wait_on(0);
        exp_addr_q.push_back(model_pc);
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready  = 1'b0;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_err   = 1'b1;
        tick();
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_err   = 1'b0;
        check("resp_err_fetch_err", {31'b0, fetch_err}, 32'd1);
        check("resp_err_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
        check("resp_err_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0100;
        bus_if.imem_req_ready  = 1'b1;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.inst_ready      = 1'b1;
        repeat (3) tick();
        clear_inputs();
        check("err_sticky", {31'b0, fetch_err}, 32'd1);
        check("err_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
        check("err_pc", pc_out, model_pc);
        check("err_fetch_cnt", fetch_cnt, model_cnt);

        // Misaligned commit loads the PC then faults.
        reset_dut();
        fetch_to_valid(32'h0000_0013);
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0002;
        tick();
        pc_w_en = 1'b0;
        check("misalign_pc", pc_out, 32'h8000_0002);
        check("misalign_fetch_err", {31'b0, fetch_err}, 32'd1);
        check("misalign_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);

        // Timeout: 255 silent WAIT cycles.
        reset_dut();
        wait_on(0);
        exp_addr_q.push_back(model_pc);
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        repeat (254) tick();
        check("timeout_254_err", {31'b0, fetch_err}, 32'd0);
        tick();
        check("timeout_255_err", {31'b0, fetch_err}, 32'd1);

        // Reset in the middle of WAIT; the late response must be ignored.
        reset_dut();
        fetch_to_valid(32'h0000_0033);
        bus_if.inst_ready = 1'b1;
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0040;
        tick();
        bus_if.inst_ready = 1'b0;
        pc_w_en = 1'b0;
        model_pc = 32'h8000_0040;
        wait_on(0);
        exp_addr_q.push_back(model_pc);
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("midwait_rst_pc", pc_out, RST_PC);
        check("midwait_rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
        exp_addr_q.delete();
        exp_inst_q.delete();
        tick();
        rst = 1'b1;
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = 32'hdead_beef;
        tick();
        bus_if.imem_resp_valid = 1'b0;
        check("post_rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
        check("post_rst_addr", bus_if.imem_req_addr, RST_PC);
        check("post_rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
        check("post_rst_fetch_cnt", fetch_cnt, 32'd0);
        tick();
        check("late_resp_ignored_inst", bus_if.inst, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
